// File: rtl/wf_dispatcher_multicu.sv
// rtl/wf_dispatcher_multicu.sv - wavefront descriptor FIFO dispatching to multiple CUs (DISPATCH_RR_EN selects round-robin)
`timescale 1ns/1ps
module wf_dispatcher_multicu #(
    parameter int NUMOFCU = 4,
    parameter int QDEPTH  = 8,
    parameter int MAXWF   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     host_wf_valid,
    output logic                     host_wf_ready,
    input  logic [14:0]              host_wf_tag,
    input  logic [3:0]               host_wf_cnt,
    input  logic [5:0]               host_wf_size,
    input  logic [8:0]               host_sgpr_base,
    input  logic [9:0]               host_vgpr_base,
    input  logic [15:0]              host_lds_base,
    input  logic [31:0]              host_start_pc,
    output logic [NUMOFCU-1:0]       dispatch2cu_wf_dispatch,
    output logic [14:0]              dispatch2cu_wf_tag_dispatch,
    output logic [3:0]               dispatch2cu_wg_wf_count,
    output logic [5:0]               dispatch2cu_wf_size_dispatch,
    output logic [8:0]               dispatch2cu_sgpr_base_dispatch,
    output logic [9:0]               dispatch2cu_vgpr_base_dispatch,
    output logic [15:0]              dispatch2cu_lds_base_dispatch,
    output logic [31:0]              dispatch2cu_start_pc_dispatch,
    input  logic [NUMOFCU-1:0]       cu2dispatch_wf_done,
    input  logic [NUMOFCU*15-1:0]    cu2dispatch_wf_tag_done,
    output logic [$clog2(QDEPTH):0]  queue_count,
    output logic [31:0]              wf_done_total,
    output logic                     err_underflow
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (NUMOFCU > 1) ? $clog2(NUMOFCU) : 1;
    localparam int DW = 92;

    logic [DW-1:0]      fifo_mem [QDEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      q_cnt;
    logic [3:0]         cu_cnt [NUMOFCU];
    logic [NUMOFCU-1:0] eligible;
    logic [NUMOFCU-1:0] grant;
    logic [NUMOFCU-1:0] done_valid;
    logic [PW-1:0]      grant_idx;
    logic               do_push;
    logic               do_pop;
    logic               underflow;
    logic [31:0]        done_inc;
    logic [DW-1:0]      push_desc;
    logic [DW-1:0]      head_desc;
    logic               tag_done_unused;

    // Done tags carry no meaning for dispatch; only the strobes are used.
    assign tag_done_unused = ^cu2dispatch_wf_tag_done;

    assign host_wf_ready = (q_cnt < CW'(QDEPTH));
    assign do_push       = host_wf_valid && host_wf_ready;
    assign push_desc     = {host_wf_tag, host_wf_cnt, host_wf_size, host_sgpr_base,
                            host_vgpr_base, host_lds_base, host_start_pc};
    assign head_desc     = fifo_mem[rd_ptr];
    assign queue_count   = q_cnt;

    always_comb begin
        eligible = '0;
        for (int n = 0; n < NUMOFCU; n++) begin
            eligible[n] = (cu_cnt[n] < 4'(MAXWF));
        end
    end

    assign do_pop = (q_cnt != '0) && (|eligible);

`ifdef DISPATCH_RR_EN
    logic [PW-1:0] rr_ptr;

    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUMOFCU; i++) begin
            idx = (int'(rr_ptr) + i) % NUMOFCU;
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (do_pop) begin
            rr_ptr <= (grant_idx == PW'(NUMOFCU - 1)) ? '0 : grant_idx + PW'(1);
        end
    end
`else
    // Descending scan so the lowest eligible index is the last (winning) assignment.
    always_comb begin
        grant_idx = '0;
        for (int i = NUMOFCU - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_idx = PW'(i);
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (do_pop) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A done coinciding with a grant is a real completion even when the counter reads 0.
    always_comb begin
        done_valid = '0;
        underflow  = 1'b0;
        done_inc   = '0;
        for (int n = 0; n < NUMOFCU; n++) begin
            done_valid[n] = cu2dispatch_wf_done[n] && ((cu_cnt[n] != 4'd0) || grant[n]);
            if (cu2dispatch_wf_done[n] && (cu_cnt[n] == 4'd0) && !grant[n]) begin
                underflow = 1'b1;
            end
            done_inc = done_inc + 32'(done_valid[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            fifo_mem[wr_ptr] <= push_desc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr                  <= '0;
            rd_ptr                  <= '0;
            q_cnt                   <= '0;
            wf_done_total           <= '0;
            err_underflow           <= 1'b0;
            dispatch2cu_wf_dispatch <= '0;
            for (int n = 0; n < NUMOFCU; n++) begin
                cu_cnt[n] <= 4'd0;
            end
            {dispatch2cu_wf_tag_dispatch, dispatch2cu_wg_wf_count, dispatch2cu_wf_size_dispatch,
             dispatch2cu_sgpr_base_dispatch, dispatch2cu_vgpr_base_dispatch,
             dispatch2cu_lds_base_dispatch, dispatch2cu_start_pc_dispatch} <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            q_cnt <= q_cnt + CW'(do_push) - CW'(do_pop);
            for (int n = 0; n < NUMOFCU; n++) begin
                if (grant[n] && !cu2dispatch_wf_done[n]) begin
                    cu_cnt[n] <= cu_cnt[n] + 4'd1;
                end else if (!grant[n] && done_valid[n]) begin
                    cu_cnt[n] <= cu_cnt[n] - 4'd1;
                end
            end
            wf_done_total <= wf_done_total + done_inc;
            if (underflow) begin
                err_underflow <= 1'b1;
            end
            dispatch2cu_wf_dispatch <= grant;
            {dispatch2cu_wf_tag_dispatch, dispatch2cu_wg_wf_count, dispatch2cu_wf_size_dispatch,
             dispatch2cu_sgpr_base_dispatch, dispatch2cu_vgpr_base_dispatch,
             dispatch2cu_lds_base_dispatch, dispatch2cu_start_pc_dispatch} <= do_pop ? head_desc : '0;
        end
    end
endmodule

// File: tb/tb_wf_dispatcher_multicu.sv
// tb/tb_wf_dispatcher_multicu.sv - self-checking bench for wf_dispatcher_multicu against a queue-based model
`timescale 1ns/1ps
module tb_wf_dispatcher_multicu;
    localparam int NCU    = 4;
    localparam int QDEPTH = 8;
    localparam int MAXWF  = 2;
`ifdef DISPATCH_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        host_wf_valid;
    logic        host_wf_ready;
    logic [91:0] host_desc;
    logic [14:0] host_wf_tag;
    logic [3:0]  host_wf_cnt;
    logic [5:0]  host_wf_size;
    logic [8:0]  host_sgpr_base;
    logic [9:0]  host_vgpr_base;
    logic [15:0] host_lds_base;
    logic [31:0] host_start_pc;
    logic [3:0]  strobe;
    logic [14:0] d_tag;
    logic [3:0]  d_cnt;
    logic [5:0]  d_size;
    logic [8:0]  d_sgpr;
    logic [9:0]  d_vgpr;
    logic [15:0] d_lds;
    logic [31:0] d_pc;
    logic [3:0]  cu_done;
    logic [59:0] cu_tag_done;
    logic [3:0]  queue_count;
    logic [31:0] wf_done_total;
    logic        err_underflow;
    logic [91:0] dut_desc;

    assign {host_wf_tag, host_wf_cnt, host_wf_size, host_sgpr_base,
            host_vgpr_base, host_lds_base, host_start_pc} = host_desc;
    assign dut_desc = {d_tag, d_cnt, d_size, d_sgpr, d_vgpr, d_lds, d_pc};

    wf_dispatcher_multicu #(.NUMOFCU(NCU), .QDEPTH(QDEPTH), .MAXWF(MAXWF)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .host_wf_valid                  (host_wf_valid),
        .host_wf_ready                  (host_wf_ready),
        .host_wf_tag                    (host_wf_tag),
        .host_wf_cnt                    (host_wf_cnt),
        .host_wf_size                   (host_wf_size),
        .host_sgpr_base                 (host_sgpr_base),
        .host_vgpr_base                 (host_vgpr_base),
        .host_lds_base                  (host_lds_base),
        .host_start_pc                  (host_start_pc),
        .dispatch2cu_wf_dispatch        (strobe),
        .dispatch2cu_wf_tag_dispatch    (d_tag),
        .dispatch2cu_wg_wf_count        (d_cnt),
        .dispatch2cu_wf_size_dispatch   (d_size),
        .dispatch2cu_sgpr_base_dispatch (d_sgpr),
        .dispatch2cu_vgpr_base_dispatch (d_vgpr),
        .dispatch2cu_lds_base_dispatch  (d_lds),
        .dispatch2cu_start_pc_dispatch  (d_pc),
        .cu2dispatch_wf_done            (cu_done),
        .cu2dispatch_wf_tag_done        (cu_tag_done),
        .queue_count                    (queue_count),
        .wf_done_total                  (wf_done_total),
        .err_underflow                  (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [91:0] mq[$];
    int          mcnt[NCU];
    int          mstart;
    logic [3:0]  m_strobe;
    logic [91:0] m_desc;
    logic [31:0] m_total;
    logic        m_err;
    int          errors;
    int          checks;

    // Next-state of the reference: inputs are read just before the edge.
    task automatic model_step();
        int g;
        int c;
        bit push;
        if (rst) begin
            mq.delete();
            for (int n = 0; n < NCU; n++) mcnt[n] = 0;
            mstart = 0; m_strobe = '0; m_desc = '0; m_total = '0; m_err = 1'b0;
            return;
        end
        push = host_wf_valid && (mq.size() < QDEPTH);
        g = -1;
        if (mq.size() > 0) begin
            for (int k = 0; k < NCU; k++) begin
                c = RR_EN ? (mstart + k) % NCU : k;
                if (g < 0 && mcnt[c] < MAXWF) g = c;
            end
        end
        m_strobe = '0;
        m_desc   = '0;
        if (g >= 0) begin
            m_desc      = mq.pop_front();
            m_strobe[g] = 1'b1;
            mstart      = (g + 1) % NCU;
        end
        for (int n = 0; n < NCU; n++) begin
            if (cu_done[n]) begin
                if (g == n) m_total++;
                else if (mcnt[n] > 0) begin mcnt[n]--; m_total++; end
                else m_err = 1'b1;
            end else if (g == n) begin
                mcnt[n]++;
            end
        end
        if (push) mq.push_back(host_desc);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_desc(output logic [91:0] d);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        d = r[91:0];
    endtask

    task automatic do_reset();
        rst = 1'b1; host_wf_valid = 1'b0; cu_done = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [91:0] d;
        rand_desc(d);
        rst = 1'b1; host_wf_valid = 1'b1; host_desc = d; cu_done = '1;
        tick();
        checks++; if (strobe !== 4'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", strobe); end
        checks++; if (dut_desc !== 92'b0) begin errors++; $display("FAIL reset_payload: got %h want 0", dut_desc); end
        checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL reset_qcount: got %0d want 0", queue_count); end
        checks++; if (wf_done_total !== 32'd0) begin errors++; $display("FAIL reset_total: got %0d want 0", wf_done_total); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_underflow); end
        checks++; if (host_wf_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", host_wf_ready); end
        rst = 1'b0; host_wf_valid = 1'b0; cu_done = '0;
    endtask

    task automatic test_single_dispatch();
        logic [91:0] d;
        do_reset();
        rand_desc(d);
        d[91:77] = 15'h0011;
        host_desc = d; host_wf_valid = 1'b1;
        tick();
        host_wf_valid = 1'b0;
        checks++; if (queue_count !== 4'd1 || strobe !== 4'b0) begin errors++; $display("FAIL single_queued: got q=%0d s=%b want q=1 s=0", queue_count, strobe); end
        tick();
        checks++; if (strobe !== 4'b0001) begin errors++; $display("FAIL single_strobe: got %b want 0001", strobe); end
        checks++; if (d_tag !== 15'h0011 || dut_desc !== d) begin errors++; $display("FAIL single_payload: got %h want %h", dut_desc, d); end
        tick();
        checks++; if (strobe !== 4'b0 || dut_desc !== 92'b0) begin errors++; $display("FAIL single_clear: got s=%b p=%h want 0", strobe, dut_desc); end
    endtask

    task automatic test_fill();
        logic [91:0] d;
        do_reset();
        host_wf_valid = 1'b1;
        for (int i = 0; i < NCU * MAXWF; i++) begin
            rand_desc(d); host_desc = d;
            tick();
        end
        host_wf_valid = 1'b0;
        tick(); tick();
        checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL fill_saturate: got q=%0d want 0", queue_count); end
        host_wf_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rand_desc(d); host_desc = d;
            tick();
            checks++;
            if (queue_count !== 4'((i + 1 > QDEPTH) ? QDEPTH : i + 1) || host_wf_ready !== (i + 1 < QDEPTH) || strobe !== 4'b0) begin
                errors++;
                $display("FAIL fill_push%0d: got q=%0d rdy=%b s=%b want q=%0d rdy=%b s=0", i, queue_count, host_wf_ready, strobe,
                         (i + 1 > QDEPTH) ? QDEPTH : i + 1, (i + 1 < QDEPTH));
            end
        end
        host_wf_valid = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [91:0] d;
        int grants[$];
        int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_fp[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        do_reset();
        for (int cyc = 0; cyc < 14; cyc++) begin
            host_wf_valid = (cyc < 8);
            rand_desc(d); host_desc = d;
            tick();
            if (strobe !== 4'b0) begin
                checks++; if (!$onehot(strobe) || strobe !== m_strobe) begin errors++; $display("FAIL arb_strobe: got %b want %b", strobe, m_strobe); end
                for (int k = 0; k < NCU; k++) if (strobe[k]) grants.push_back(k);
            end
        end
        host_wf_valid = 1'b0;
        checks++; if (grants.size() != 8) begin errors++; $display("FAIL arb_count: got %0d want 8", grants.size()); end
        for (int i = 0; i < 8 && i < grants.size(); i++) begin
            checks++;
            if (grants[i] != (RR_EN ? exp_rr[i] : exp_fp[i])) begin
                errors++; $display("FAIL arb_order%0d: got CU%0d want CU%0d", i, grants[i], RR_EN ? exp_rr[i] : exp_fp[i]);
            end
        end
    endtask

    task automatic test_done_same_cycle();
        logic [91:0] d;
        rand_desc(d);
        host_desc = d; host_wf_valid = 1'b1;
        tick();
        host_wf_valid = 1'b0;
        tick(); tick();
        checks++; if (queue_count !== 4'd1 || strobe !== 4'b0) begin errors++; $display("FAIL done_pending: got q=%0d s=%b want q=1 s=0", queue_count, strobe); end
        cu_done = 4'b0100;
        tick();
        cu_done = 4'b0000;
        checks++; if (strobe !== 4'b0) begin errors++; $display("FAIL done_nogrant: got %b want 0", strobe); end
        checks++; if (wf_done_total !== 32'd1) begin errors++; $display("FAIL done_total: got %0d want 1", wf_done_total); end
        tick();
        checks++; if (strobe !== 4'b0100 || dut_desc !== d || queue_count !== 4'd0) begin
            errors++; $display("FAIL done_regrant: got s=%b q=%0d p=%h want s=0100 q=0 p=%h", strobe, queue_count, dut_desc, d);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cu_done = 4'b0010;
        tick();
        cu_done = 4'b0000;
        checks++; if (err_underflow !== 1'b1 || wf_done_total !== 32'd0) begin
            errors++; $display("FAIL underflow_set: got err=%b total=%0d want err=1 total=0", err_underflow, wf_done_total);
        end
        tick(); tick(); tick();
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b want 1", err_underflow); end
    endtask

    task automatic test_reset_mid_burst();
        logic [91:0] d;
        do_reset();
        host_wf_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_desc(d); host_desc = d; cu_done = (i == 3) ? 4'b0001 : 4'b0000;
            tick();
        end
        rst = 1'b1; cu_done = 4'b1111;
        tick();
        rst = 1'b0; host_wf_valid = 1'b0; cu_done = '0;
        checks++; if (strobe !== 4'b0 || dut_desc !== 92'b0) begin errors++; $display("FAIL midrst_outputs: got s=%b p=%h want 0", strobe, dut_desc); end
        checks++; if (queue_count !== 4'd0 || host_wf_ready !== 1'b1) begin errors++; $display("FAIL midrst_queue: got q=%0d rdy=%b want q=0 rdy=1", queue_count, host_wf_ready); end
        checks++; if (wf_done_total !== 32'd0 || err_underflow !== 1'b0) begin errors++; $display("FAIL midrst_stats: got total=%0d err=%b want 0", wf_done_total, err_underflow); end
    endtask

    task automatic test_random();
        logic [91:0] d;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            host_wf_valid = ($urandom_range(0, 3) != 0);
            rand_desc(d); host_desc = d;
            for (int n = 0; n < NCU; n++) cu_done[n] = ($urandom_range(0, 3) == 0);
            cu_tag_done = {$urandom(), $urandom()};
            tick();
            checks++; if (strobe !== m_strobe) begin errors++; $display("FAIL rand_strobe@%0d: got %b want %b", cyc, strobe, m_strobe); end
            checks++; if (dut_desc !== m_desc) begin errors++; $display("FAIL rand_payload@%0d: got %h want %h", cyc, dut_desc, m_desc); end
            checks++; if (queue_count !== 4'(mq.size()) || host_wf_ready !== (mq.size() < QDEPTH)) begin
                errors++; $display("FAIL rand_queue@%0d: got q=%0d rdy=%b want q=%0d", cyc, queue_count, host_wf_ready, mq.size());
            end
            checks++; if (wf_done_total !== m_total) begin errors++; $display("FAIL rand_total@%0d: got %0d want %0d", cyc, wf_done_total, m_total); end
            checks++; if (err_underflow !== m_err) begin errors++; $display("FAIL rand_err@%0d: got %b want %b", cyc, err_underflow, m_err); end
        end
        host_wf_valid = 1'b0; cu_done = '0;
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; host_wf_valid = 1'b0; host_desc = '0; cu_done = '0; cu_tag_done = '0;
        mstart = 0; m_strobe = '0; m_desc = '0; m_total = '0; m_err = 1'b0;
        for (int n = 0; n < NCU; n++) mcnt[n] = 0;
        #1;
        test_reset();
        test_single_dispatch();
        test_fill();
        test_arbitration();
        test_done_same_cycle();
        test_underflow();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
